// File: rtl/bird_pkg.sv
// Shared types and constants for the bird column referee.
// Game state encoding, bird column index and default row count.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_t;

    localparam int BIRD_COL = 12;
    localparam int ROWS_DEF = 16;

endpackage

// File: rtl/bird_referee_bcd.sv
// bcd_counter2: two-digit BCD counter, saturating at 99.
// Ports: clk, reset (async high), clr (priority), inc, cnt[7:0] {tens,ones}.
module bcd_counter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 8'h00;
        end else if (clr) begin
            cnt <= 8'h00;
        end else if (inc && cnt != 8'h99) begin
            if (cnt[3:0] == 4'd9) begin
                cnt <= {cnt[7:4] + 4'd1, 4'd0};
            end else begin
                cnt <= {cnt[7:4], cnt[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/bird_referee.sv
// bird_referee: collision / game-over referee and BCD pipe score for the bird column.
// Ports: clk, reset (async high), start, birdState[ROWS], pipeCol[ROWS], pipePass,
//        Over, playing, score[7:0]; best[7:0] only when HIGH_SCORE_EN is defined.
module bird_referee
    import bird_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int GROUND_HOLD = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ROWS-1:0] birdState,
    input  logic [ROWS-1:0] pipeCol,
    input  logic            pipePass,
    output logic            Over,
    output logic            playing,
    output logic [7:0]      score
`ifdef HIGH_SCORE_EN
    ,
    output logic [7:0]      best
`endif
);

    localparam int GW = $clog2(GROUND_HOLD + 1);

    game_state_t   state, state_next;
    logic          start_q;
    logic          start_edge;
    logic [GW-1:0] ground_cnt;
    logic          hit;
    logic          score_clr;
    logic          score_inc;

    assign start_edge = start & ~start_q;

    // Any overlap counts, so a malformed multi-hot bird still collides.
    always_comb begin
        hit = 1'b0;
        if (state == PLAY) begin
            hit = (|(birdState & pipeCol))
                | (birdState == '0)
                | ((ground_cnt == GW'(GROUND_HOLD - 1)) & birdState[0]);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_edge) state_next = PLAY;
            PLAY: if (hit)        state_next = OVER;
            OVER: if (start_edge) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            ground_cnt <= '0;
            Over       <= 1'b0;
            playing    <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= start;
            Over    <= (state_next == OVER);
            playing <= (state_next == PLAY);
            if (state_next != state) begin
                ground_cnt <= '0;
            end else if (state == PLAY && birdState[0]) begin
                ground_cnt <= ground_cnt + GW'(1);
            end else begin
                ground_cnt <= '0;
            end
        end
    end

    // Hit wins over a simultaneous pass.
    assign score_clr = (state == IDLE) & start_edge;
    assign score_inc = (state == PLAY) & pipePass & ~hit;

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .cnt   (score)
    );

`ifdef HIGH_SCORE_EN
    // BCD digits order the same as binary, so a plain compare works.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best <= 8'h00;
        end else if (state == PLAY && hit && score > best) begin
            best <= score;
        end
    end
`endif

endmodule

// File: tb/tb_bird_referee.sv
// Scoreboard bench for bird_referee: game-level reference model, directed
// scenarios followed by randomized play; monitor compares every cycle.
module tb_bird_referee;

    localparam int ROWS = 16;
    localparam int GH   = 4;

    typedef struct packed {
        logic       over;
        logic       play;
        logic [7:0] score;
        logic [7:0] best;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [ROWS-1:0] birdState = '0;
    logic [ROWS-1:0] pipeCol = '0;
    logic            pipePass = 1'b0;
    logic            Over;
    logic            playing;
    logic [7:0]      score;
    logic [7:0]      best;

    bird_referee #(.ROWS(ROWS), .GROUND_HOLD(GH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .birdState (birdState),
        .pipeCol   (pipeCol),
        .pipePass  (pipePass),
        .Over      (Over),
        .playing   (playing),
        .score     (score)
`ifdef HIGH_SCORE_EN
        ,
        .best      (best)
`endif
    );

`ifndef HIGH_SCORE_EN
    assign best = 8'h00;
`endif

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Game-level model: mode 0 waiting, 1 in a game, 2 game finished.
    int mode = 0;
    int m_score = 0;
    int m_best = 0;
    int m_run = 0;
    bit m_prev_start = 0;

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic exp_t expected();
        exp_t e;
        e.over  = (mode == 2);
        e.play  = (mode == 1);
        e.score = bcd(m_score);
`ifdef HIGH_SCORE_EN
        e.best  = bcd(m_best);
`else
        e.best  = 8'h00;
`endif
        return e;
    endfunction

    task automatic model_step();
        bit edge_seen;
        bit crash;
        if (reset) begin
            mode = 0; m_score = 0; m_best = 0; m_run = 0;
            m_prev_start = 0;
            return;
        end
        edge_seen = start && !m_prev_start;
        m_prev_start = start;
        if (mode == 0) begin
            if (edge_seen) begin
                mode = 1; m_score = 0; m_run = 0;
            end
        end else if (mode == 1) begin
            crash = ((birdState & pipeCol) != 0) || (birdState == 0)
                 || (birdState[0] && m_run >= GH - 1);
            if (crash) begin
                if (m_score > m_best) m_best = m_score;
                mode = 2; m_run = 0;
            end else begin
                if (pipePass && m_score < 99) m_score++;
                m_run = birdState[0] ? m_run + 1 : 0;
            end
        end else begin
            if (edge_seen) mode = 0;
        end
    endtask

    task automatic step(input bit s, input logic [15:0] b,
                        input logic [15:0] p, input bit pp);
        @(negedge clk);
        start = s; birdState = b; pipeCol = p; pipePass = pp;
        model_step();
        q.push_back(expected());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (Over !== 1'b0 || playing !== 1'b0 || score !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: got Over=%b playing=%b score=%h, want 0 0 00",
                     Over, playing, score);
        end
        model_step();
        q.push_back(expected());
        @(negedge clk);
        reset = 1'b0;
        model_step();
        q.push_back(expected());
    endtask

    task automatic begin_game();
        step(0, 16'h0100, 16'h0, 0);
        step(1, 16'h0100, 16'h0, 0);
        step(0, 16'h0100, 16'h0, 0);
    endtask

    task automatic end_game_at(input int n);
        if (mode != 1) begin_game();
        repeat (n) step(0, 16'h0100, 16'h0, 1);
        step(0, 16'h0100, 16'hF0FF, 0);
        step(1, 16'h0100, 16'h0, 0);
        step(0, 16'h0100, 16'h0, 0);
    endtask

    // Monitor: one observation per clock, compared against the queued value.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (Over !== e.over || playing !== e.play || score !== e.score
`ifdef HIGH_SCORE_EN
                || best !== e.best
`endif
            ) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got Over=%b playing=%b score=%h best=%h, want %b %b %h %h",
                         $time, Over, playing, score, best,
                         e.over, e.play, e.score, e.best);
            end
        end
    end

    initial begin
        int r;
        logic [15:0] b, p;
        // Reset state, then start and three passes.
        step(0, 16'h0100, 16'h0, 0);
        @(negedge clk);
        reset = 1'b0;
        begin_game();
        repeat (3) begin
            step(0, 16'h0100, 16'h0, 1);
            step(0, 16'h0100, 16'h0, 0);
        end
        // Pipe collision, later passes ignored.
        step(0, 16'h0100, 16'hF0FF, 0);
        repeat (3) step(0, 16'h0100, 16'h0, 1);
        // Back to IDLE, new game, ground timeout.
        step(1, 16'h0100, 16'h0, 0);
        begin_game();
        repeat (3) step(0, 16'h0001, 16'h0, 0);
        step(0, 16'h0002, 16'h0, 0);
        repeat (3) step(0, 16'h0001, 16'h0, 0);
        step(0, 16'h0002, 16'h0, 0);
        repeat (5) step(0, 16'h0001, 16'h0, 0);
        // Saturation at 99.
        step(1, 16'h0100, 16'h0, 0);
        begin_game();
        repeat (102) step(0, 16'h0100, 16'h0, 1);
        // Hit coincident with pass; lost bird.
        step(0, 16'h0100, 16'h0100, 1);
        step(1, 16'h0100, 16'h0, 0);
        begin_game();
        step(0, 16'h0200, 16'h0, 1);
        step(0, 16'h0000, 16'h0, 1);
        step(0, 16'h0200, 16'h0, 0);
        // Asynchronous reset mid-game.
        step(1, 16'h0100, 16'h0, 0);
        begin_game();
        repeat (4) step(0, 16'h0100, 16'h0, 1);
        do_reset();
        // Best-score sequence: 5, 3, 12.
        end_game_at(5);
        end_game_at(3);
        end_game_at(12);
        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) b = 16'h0;
            else if (r <= 4) b = 16'h0001;
            else if (r == 5) b = 16'($urandom);
            else b = 16'h1 << $urandom_range(1, 15);
            p = ($urandom_range(0, 9) < 8) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) == 0) ? ~start : start, b, p,
                     $urandom_range(0, 2) != 0);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
